// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared states and blocked-phase patterns for the parking sensor emulator
package parking_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PH1,
    ST_PH2,
    ST_PH3,
    ST_GAP
  } state_t;

  // Blocked patterns {a,b}, 1 = barrier blocked
  localparam logic [1:0] ENTRY_PH1 = 2'b10;
  localparam logic [1:0] ENTRY_PH3 = 2'b01;
  localparam logic [1:0] EXIT_PH1  = 2'b01;
  localparam logic [1:0] EXIT_PH3  = 2'b10;
  localparam logic [1:0] BOTH      = 2'b11;
  localparam logic [1:0] NONE      = 2'b00;

  function automatic logic [1:0] blocked_pattern(input state_t st, input logic dir);
    case (st)
      ST_PH1:  return dir ? ENTRY_PH1 : EXIT_PH1;
      ST_PH2:  return BOTH;
      ST_PH3:  return dir ? ENTRY_PH3 : EXIT_PH3;
      default: return NONE;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable dwell down-counter with expire flag
module phase_timer #(
  parameter int unsigned DWELL_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic expire
);

  localparam int CW = $clog2(DWELL_CYCLES + 1);

  logic [CW-1:0] count;

  // Loaded with the full dwell; the phase ends on the cycle the count reads 1
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(DWELL_CYCLES);
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign expire = (count == CW'(1));

endmodule

// File: rtl/parking_sensor_emulator.sv
// rtl/parking_sensor_emulator.sv - emulates barrier A/B waveforms of one vehicle passage per request
module parking_sensor_emulator
  import parking_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic req_valid,
  input  logic req_dir,
  output logic req_ready,
  output logic sensor_a,
  output logic sensor_b,
  output logic busy,
  output logic done
);

  state_t     state, state_next;
  logic       dir, dir_next;
  logic       load, expire;
  logic [1:0] blocked_next;

  phase_timer #(.DWELL_CYCLES(DWELL_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .expire (expire)
  );

  always_comb begin
    state_next = state;
    dir_next   = dir;
    load       = 1'b0;
    case (state)
      ST_IDLE: if (req_valid) begin
        state_next = ST_PH1;
        dir_next   = req_dir;
        load       = 1'b1;
      end
      ST_PH1: if (expire) begin
        state_next = ST_PH2;
        load       = 1'b1;
      end
      ST_PH2: if (expire) begin
        state_next = ST_PH3;
        load       = 1'b1;
      end
      ST_PH3: if (expire) begin
        state_next = ST_GAP;
        load       = 1'b1;
      end
      ST_GAP: if (expire) begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    blocked_next = blocked_pattern(state_next, dir_next);
  end

  // Outputs are registered from the next phase so they line up with the state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      dir      <= 1'b0;
      sensor_a <= 1'b1;
      sensor_b <= 1'b1;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      dir      <= dir_next;
      sensor_a <= ~blocked_next[1];
      sensor_b <= ~blocked_next[0];
      done     <= (state == ST_PH3) && (state_next == ST_GAP);
    end
  end

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_parking_sensor_emulator.sv
// tb/tb_parking_sensor_emulator.sv - directed self-checking bench for parking_sensor_emulator
module tb_parking_sensor_emulator;

  logic clk = 1'b0;
  logic reset;
  logic req_valid, req_dir, req_ready, sensor_a, sensor_b, busy, done;
  logic req_valid1, req_dir1, req_ready1, sensor_a1, sensor_b1, busy1, done1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parking_sensor_emulator #(.DWELL_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_dir   (req_dir),
    .req_ready (req_ready),
    .sensor_a  (sensor_a),
    .sensor_b  (sensor_b),
    .busy      (busy),
    .done      (done)
  );

  parking_sensor_emulator #(.DWELL_CYCLES(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid1),
    .req_dir   (req_dir1),
    .req_ready (req_ready1),
    .sensor_a  (sensor_a1),
    .sensor_b  (sensor_b1),
    .busy      (busy1),
    .done      (done1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {sensor_a,sensor_b} n cycles after acceptance, DWELL_CYCLES=4
  function automatic logic [1:0] exp_pair(input int n, input logic d);
    if (n <= 4)       return d ? 2'b01 : 2'b10;
    else if (n <= 8)  return 2'b00;
    else if (n <= 12) return d ? 2'b10 : 2'b01;
    else              return 2'b11;
  endfunction

  // Called at a negedge while idle; accepted on the next posedge
  task automatic run_passage(input logic d, input string name);
    req_valid = 1'b1;
    req_dir   = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_dir   = ~d;
    for (int n = 1; n <= 17; n++) begin
      if (n > 1) @(negedge clk);
      check($sformatf("%s_c%0d_sensors", name, n), 32'({sensor_a, sensor_b}), 32'(exp_pair(n, d)));
      check($sformatf("%s_c%0d_done", name, n), 32'(done), (n == 13) ? 1 : 0);
      check($sformatf("%s_c%0d_busy", name, n), 32'(busy), (n <= 16) ? 1 : 0);
      check($sformatf("%s_c%0d_ready", name, n), 32'(req_ready), (n == 17) ? 1 : 0);
    end
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (!(req_ready && req_ready1) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("wait_idle", 32'(req_ready && req_ready1), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen_done;
    reset = 1'b1;
    req_valid = 1'b0; req_dir = 1'b0;
    req_valid1 = 1'b0; req_dir1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sensors", 32'({sensor_a, sensor_b}), 32'h3);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ready", 32'(req_ready), 1);
    check("rst_sensors_d1", 32'({sensor_a1, sensor_b1}), 32'h3);
    reset = 1'b0;
    @(negedge clk);

    run_passage(1'b1, "entry");
    run_passage(1'b0, "exit");

    // Held request with direction toggling every cycle
    for (int m = 0; m <= 35; m++) begin
      if (m > 0) @(negedge clk);
      case (m)
        1:  check("b2b_m1_sensors", 32'({sensor_a, sensor_b}), 32'h2);
        16: check("b2b_m16_ready", 32'(req_ready), 0);
        17: begin
          check("b2b_m17_ready", 32'(req_ready), 1);
          check("b2b_m17_sensors", 32'({sensor_a, sensor_b}), 32'h3);
        end
        18: begin
          check("b2b_m18_ready", 32'(req_ready), 0);
          check("b2b_m18_sensors", 32'({sensor_a, sensor_b}), 32'h1);
        end
        33: check("b2b_m33_busy", 32'(busy), 1);
        34: check("b2b_m34_ready", 32'(req_ready), 1);
        35: check("b2b_m35_sensors", 32'({sensor_a, sensor_b}), 32'h2);
        default: ;
      endcase
      req_valid = 1'b1;
      req_dir   = (m % 2 == 1);
    end
    req_valid = 1'b0;
    wait_idle(40);

    // Reset in the middle of an entry, together with a pending request
    req_valid = 1'b1;
    req_dir   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_c6_sensors", 32'({sensor_a, sensor_b}), 32'h0);
    reset = 1'b1;
    req_valid = 1'b1;
    @(negedge clk);
    check("abort_sensors", 32'({sensor_a, sensor_b}), 32'h3);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_ready", 32'(req_ready), 1);
    reset = 1'b0;
    req_valid = 1'b0;
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen_done = seen_done | done;
    end
    check("abort_no_done", 32'(seen_done), 0);
    run_passage(1'b0, "post_abort_exit");

    // One-cycle phases
    req_valid1 = 1'b1;
    req_dir1   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid1 = 1'b0;
    check("d1_c1_sensors", 32'({sensor_a1, sensor_b1}), 32'h1);
    check("d1_c1_busy", 32'(busy1), 1);
    @(negedge clk);
    check("d1_c2_sensors", 32'({sensor_a1, sensor_b1}), 32'h0);
    @(negedge clk);
    check("d1_c3_sensors", 32'({sensor_a1, sensor_b1}), 32'h2);
    check("d1_c3_done", 32'(done1), 0);
    @(negedge clk);
    check("d1_c4_sensors", 32'({sensor_a1, sensor_b1}), 32'h3);
    check("d1_c4_done", 32'(done1), 1);
    check("d1_c4_ready", 32'(req_ready1), 0);
    @(negedge clk);
    check("d1_c5_ready", 32'(req_ready1), 1);
    check("d1_c5_done", 32'(done1), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/parking_sensor_emulator.md
PARKING_SENSOR_EMULATOR -- requirements
Module: parking_sensor_emulator

Interface
REQ-001 Parameter: DWELL_CYCLES, default 16, clock cycles each sensor phase is held; legal range 1..65535.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req_valid  input  1  request to emulate one vehicle passage.
REQ-005 Port: req_dir  input  1  1 = entry (a then b), 0 = exit (b then a); sampled only on acceptance.
REQ-006 Port: req_ready  output  1  high only in IDLE; request accepted on an edge where req_valid and req_ready are both high.
REQ-007 Port: sensor_a  output  1  emulated barrier A, active-low (1 = unblocked).
REQ-008 Port: sensor_b  output  1  emulated barrier B, active-low (1 = unblocked).
REQ-009 Port: busy  output  1  high whenever state is not IDLE.
REQ-010 Port: done  output  1  one-cycle pulse when the final blocked phase ends.

Function
REQ-011 States: IDLE, PH1, PH2, PH3, GAP; sensor_a, sensor_b, done registered, no combinational path from inputs to them.
REQ-012 Blocked pattern {a,b} (active-true): entry PH1=10, PH2=11, PH3=01; exit PH1=01, PH2=11, PH3=10; IDLE and GAP=00; sensor outputs are the inversion.
REQ-013 IDLE -> PH1 on acceptance; req_dir latched into a direction register at that edge; later req_dir changes ignored.
REQ-014 Each of PH1, PH2, PH3, GAP lasts exactly DWELL_CYCLES cycles, then PH1->PH2->PH3->GAP->IDLE.
REQ-015 Sensor outputs reflect the new phase in the cycle immediately following the transition edge (latency 1 from acceptance).
REQ-016 done high for exactly one cycle: the first cycle of GAP.
REQ-017 Total occupancy per request: 4*DWELL_CYCLES cycles from acceptance edge to the edge returning to IDLE; req_ready high the following cycle.
REQ-018 req_valid while busy: no effect, no queuing; it is accepted only when IDLE is reached and it is still high.
REQ-019 Back-to-back: req_valid held high yields a new acceptance on the first IDLE cycle, so IDLE persists exactly 1 cycle between passages.
REQ-020 Dwell counter width = ceil(log2(DWELL_CYCLES+1)); loaded on each phase entry, decrements, never wraps; DWELL_CYCLES=1 gives one-cycle phases.
REQ-021 Sensor outputs never have both low except in PH2; no direct 00<->11 transition of {a,b} ever occurs (single-bit changes only).

Reset
REQ-022 reset high at a rising edge: state=IDLE, counter=0, direction=0, sensor_a=1, sensor_b=1, done=0, busy=0; req_ready high the next cycle.
REQ-023 Reset mid-passage aborts immediately, no done pulse, no completion of remaining phases; reset dominates simultaneous req_valid.

Structure
REQ-024 Shared package parking_pkg holds the state enumeration and the four 2-bit phase pattern constants (entry/exit x PH1/PH3, plus BOTH=11, NONE=00) for reuse by the parking FSM and testbenches.
REQ-025 One sub-module, phase_timer (load, count-down, expire flag), parameterised by DWELL_CYCLES; everything else in the top.

Verification (DWELL_CYCLES=4 unless stated)
REQ-026 Entry: req_valid=1,req_dir=1 for 1 cycle at accept edge k -> {sensor_a,sensor_b}=01 cycles k+1..k+4, 00 k+5..k+8, 10 k+9..k+12, 11 from k+13; done=1 only at k+13; req_ready=1 at k+17.
REQ-027 Exit: req_dir=0 -> 10 for 4 cycles, 00 for 4, 01 for 4, then 11; done once.
REQ-028 Held req_valid=1 with req_dir toggling every cycle -> each passage uses the direction sampled at its own acceptance; exactly 1 IDLE cycle between passages.
REQ-029 Reset asserted at cycle k+6 of an entry -> sensors 11, busy=0, done never pulses, next request starts fresh at PH1.
REQ-030 DWELL_CYCLES=1 -> sequence 01,00,10,11 on consecutive cycles, done at 4th cycle, req_ready at 5th.
REQ-031 Loopback: emulator outputs through existing debouncers and parking FSM/counter; 3 entries then 1 exit -> count=2.
